// File: rtl/ip_access_ctrl_if.sv
// Bus bundle between the CPU decode stage, the access controller and the
// attached IP blocks. The controller takes the master view; the
// surrounding system (CPU pipeline plus IPs) takes the slave view.
`timescale 1ns/1ps
interface ip_access_ctrl_if #(
  parameter int NUM_IP = 4,
  parameter int SEL_W  = 5,
  parameter int DATA_W = 32
);
  // CPU decode side
  logic [5:0]               opcode;
  logic [SEL_W-1:0]         subopcode;
  logic                     issue;
  logic                     stall;
  logic                     IP_write;
  logic [DATA_W-1:0]        rdata;
  logic                     err;
  logic [1:0]               err_code;
  // IP side
  logic [NUM_IP-1:0]        ip_ready;
  logic [NUM_IP*DATA_W-1:0] ip_rdata;
  logic [NUM_IP-1:0]        ip_sel;
  logic                     ip_req;
  logic                     datarw;
  logic                     dataena;

  modport master (
    input  opcode, subopcode, issue, ip_ready, ip_rdata,
    output ip_sel, ip_req, datarw, dataena, IP_write, rdata, stall, err, err_code
  );

  modport slave (
    output opcode, subopcode, issue, ip_ready, ip_rdata,
    input  ip_sel, ip_req, datarw, dataena, IP_write, rdata, stall, err, err_code
  );
endinterface

// File: rtl/ip_access_ctrl.sv
// LWIP/SWIP access controller for NUM_IP attached IP blocks. Decodes the
// instruction, runs a req/ready handshake with the IP picked by subopcode,
// stalls the pipeline while the access is in flight, captures load data and
// reports illegal-index or timeout errors.
`timescale 1ns/1ps
module ip_access_ctrl #(
  parameter int NUM_IP  = 4,
  parameter int SEL_W   = 5,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input logic              clk,
  input logic              rst,
  ip_access_ctrl_if.master bus
);

  localparam logic [5:0] OP_LWIP = 6'b111111;
  localparam logic [5:0] OP_SWIP = 6'b111110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE,
    S_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_IP-1:0]   sel_oh_q, sel_oh_d;
  logic                rw_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   rdata_q;
  logic [1:0]          err_code_q;

  logic                is_mem_op;
  logic                req_ok;
  logic                req_bad;
  logic                ready_sel;
  logic                timeout;
  logic                stall_c;
  logic [DATA_W-1:0]   rdata_sel;

  // One-hot decode of subopcode; an out-of-range index yields all zeros.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sel_oh_d = '0;
    for (int i = 0; i < NUM_IP; i++) begin
      sel_oh_d[i] = (bus.subopcode == SEL_W'(i));
    end
  end

  assign is_mem_op = bus.issue && ((bus.opcode == OP_LWIP) || (bus.opcode == OP_SWIP));
  assign req_ok    = is_mem_op && (|sel_oh_d);
  assign req_bad   = is_mem_op && !(|sel_oh_d);
  assign timeout   = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Pick ready and read data of the latched IP; other IPs are ignored.
  always_comb begin
    ready_sel = |(bus.ip_ready & sel_oh_q);
    rdata_sel = '0;
    for (int i = 0; i < NUM_IP; i++) begin
      if (sel_oh_q[i]) rdata_sel = bus.ip_rdata[i*DATA_W +: DATA_W];
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; stall is combinational so it covers the issue cycle.
  always_comb begin
    state_d = state_q;
    stall_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_ok) begin
          state_d = S_ACCESS;
          stall_c = 1'b1;
        end else if (req_bad) begin
          state_d = S_ERR;
        end
      end
      S_ACCESS: begin
        stall_c = 1'b1;
        // Ready is checked first, so it wins over a coincident timeout.
        if (ready_sel)    state_d = S_DONE;
        else if (timeout) state_d = S_ERR;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Access context, timeout counter, load data and error code registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_oh_q   <= '0;
      rw_q       <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_code_q <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (req_ok) begin
            sel_oh_q <= sel_oh_d;
            rw_q     <= (bus.opcode == OP_SWIP);
          end else if (req_bad) begin
            err_code_q <= 2'b01;
          end
        end
        S_ACCESS: begin
          cnt_q <= cnt_q + 1'b1;
          if (ready_sel) begin
            // Stores never touch the load data register.
            if (!rw_q) rdata_q <= rdata_sel;
          end else if (timeout) begin
            err_code_q <= 2'b10;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  // Outputs are decoded from the state and the latched context only.
  assign bus.ip_req   = (state_q == S_ACCESS);
  assign bus.ip_sel   = (state_q == S_ACCESS) ? sel_oh_q : '0;
  assign bus.datarw   = (state_q == S_ACCESS) && rw_q;
  assign bus.dataena  = (state_q == S_ACCESS) && !rw_q;
  assign bus.IP_write = (state_q == S_DONE) && !rw_q;
  assign bus.err      = (state_q == S_ERR);
  assign bus.rdata    = rdata_q;
  assign bus.err_code = err_code_q;
  assign bus.stall    = stall_c;

endmodule

// File: tb/tb_ip_access_ctrl.sv
// Scoreboard bench for ip_access_ctrl: the stimulus pushes the expected
// outcome of each instruction, the monitor rebuilds each finished access
// from the bus and compares it against the queue head.
`timescale 1ns/1ps
module tb_ip_access_ctrl;

  localparam int NUM_IP  = 4;
  localparam int SEL_W   = 5;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  localparam logic [5:0] LWIP = 6'b111111;
  localparam logic [5:0] SWIP = 6'b111110;

  typedef struct {
    int          req_n;
    logic [3:0]  sel;
    int          rw_n;
    int          ena_n;
    logic        ip_write;
    logic        err;
    logic [1:0]  code;
    logic [31:0] rdata;
  } txn_t;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  txn_t exp_q[$];

  ip_access_ctrl_if #(.NUM_IP(NUM_IP), .SEL_W(SEL_W), .DATA_W(DATA_W)) bus ();

  ip_access_ctrl #(
    .NUM_IP(NUM_IP), .SEL_W(SEL_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(input int req_n, input logic [3:0] sel, input int rw_n,
                              input int ena_n, input logic ip_write, input logic err,
                              input logic [1:0] code, input logic [31:0] rdata);
    txn_t t;
    t.req_n = req_n; t.sel = sel; t.rw_n = rw_n; t.ena_n = ena_n;
    t.ip_write = ip_write; t.err = err; t.code = code; t.rdata = rdata;
    return t;
  endfunction

  // Monitor: accumulate one access, compare when it ends (DONE/ERR cycle).
  int         m_req_n, m_rw_n, m_ena_n;
  logic [3:0] m_sel;
  logic       m_prev_req;
  logic       m_stall_bad;

  always @(negedge clk) begin
    txn_t e;
    if (rst) begin
      m_req_n = 0; m_rw_n = 0; m_ena_n = 0; m_sel = '0;
      m_prev_req = 1'b0; m_stall_bad = 1'b0;
    end else begin
      if (bus.ip_req) begin
        m_req_n++;
        if (bus.datarw)  m_rw_n++;
        if (bus.dataena) m_ena_n++;
        m_sel = m_sel | bus.ip_sel;
        if (!bus.stall) m_stall_bad = 1'b1;
      end else if (m_prev_req || bus.err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_access_end", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("req_cycles",   m_req_n,      e.req_n);
          check("ip_sel",       m_sel,        e.sel);
          check("datarw_cyc",   m_rw_n,       e.rw_n);
          check("dataena_cyc",  m_ena_n,      e.ena_n);
          check("IP_write",     bus.IP_write, e.ip_write);
          check("err",          bus.err,      e.err);
          check("err_code",     bus.err_code, e.code);
          check("rdata",        bus.rdata,    e.rdata);
          check("stall_in_acc", m_stall_bad,  1'b0);
          check("stall_at_end", bus.stall,    1'b0);
        end
        m_req_n = 0; m_rw_n = 0; m_ena_n = 0; m_sel = '0; m_stall_bad = 1'b0;
      end
      m_prev_req = bus.ip_req;
    end
  end

  // Issue one instruction and play the IP side for n_cycles ACCESS cycles.
  // ready_at = ACCESS cycle (1-based) in which the selected IP is ready, 0 = never.
  // noise is ORed into ip_ready on odd ACCESS cycles.
  task automatic run_op(input logic [5:0] op, input logic [4:0] sub, input int ready_at,
                        input int n_cycles, input logic [31:0] data, input logic [3:0] noise,
                        input logic exp_stall);
    logic [3:0] m;
    m = '0;
    if (sub < 5'd4) m[sub[1:0]] = 1'b1;
    for (int i = 0; i < NUM_IP; i++) bus.ip_rdata[i*DATA_W +: DATA_W] = 32'hBAD0_0000 | 32'(i);
    if (sub < 5'd4) bus.ip_rdata[int'(sub)*DATA_W +: DATA_W] = data;
    @(posedge clk); #1;
    bus.opcode = op; bus.subopcode = sub; bus.issue = 1'b1;
    @(negedge clk);
    check("stall_at_issue", bus.stall, exp_stall);
    @(posedge clk); #1;
    bus.issue = 1'b0; bus.opcode = 6'h00; bus.subopcode = '0;
    for (int k = 1; k <= n_cycles; k++) begin
      bus.ip_ready = (k % 2 == 1) ? noise : 4'b0000;
      if (k == ready_at) bus.ip_ready = bus.ip_ready | m;
      @(posedge clk); #1;
    end
    bus.ip_ready = '0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.opcode = '0; bus.subopcode = '0; bus.issue = 1'b0;
    bus.ip_ready = '0; bus.ip_rdata = '0;
    #3;
    check("rst_ip_req",   bus.ip_req,   0);
    check("rst_ip_sel",   bus.ip_sel,   0);
    check("rst_stall",    bus.stall,    0);
    check("rst_err",      bus.err,      0);
    check("rst_err_code", bus.err_code, 0);
    check("rst_rdata",    bus.rdata,    0);
    check("rst_IP_write", bus.IP_write, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Load from IP 2, ready in the third ACCESS cycle.
    exp_q.push_back(mk(3, 4'b0100, 0, 3, 1'b1, 1'b0, 2'b00, 32'hDEADBEEF));
    run_op(LWIP, 5'd2, 3, 3, 32'hDEADBEEF, 4'b0000, 1'b1);

    // Store to IP 0, ready at once; rdata must not change.
    exp_q.push_back(mk(1, 4'b0001, 1, 0, 1'b0, 1'b0, 2'b00, 32'hDEADBEEF));
    run_op(SWIP, 5'd0, 1, 1, 32'h12345678, 4'b0000, 1'b1);

    // Illegal index: no request, error code 01, no stall.
    exp_q.push_back(mk(0, 4'b0000, 0, 0, 1'b0, 1'b1, 2'b01, 32'hDEADBEEF));
    run_op(LWIP, 5'd5, 0, 0, 32'h0, 4'b0000, 1'b0);

    // Non-IP opcode with issue: nothing at all happens.
    run_op(6'h23, 5'd1, 0, 0, 32'h0, 4'b0000, 1'b0);

    // Timeout on IP 1: TIMEOUT request cycles, then error code 10.
    exp_q.push_back(mk(TIMEOUT, 4'b0010, 0, TIMEOUT, 1'b0, 1'b1, 2'b10, 32'hDEADBEEF));
    run_op(LWIP, 5'd1, 0, TIMEOUT, 32'h0, 4'b0000, 1'b1);

    // Load from IP 3 while IPs 0 and 1 pulse ready; only ready[3] counts.
    exp_q.push_back(mk(5, 4'b1000, 0, 5, 1'b1, 1'b0, 2'b10, 32'hCAFEF00D));
    run_op(LWIP, 5'd3, 5, 5, 32'hCAFEF00D, 4'b0011, 1'b1);

    // Ready arrives on the last allowed cycle: ready wins over timeout.
    exp_q.push_back(mk(TIMEOUT, 4'b0010, 0, TIMEOUT, 1'b1, 1'b0, 2'b10, 32'h0BADCAFE));
    run_op(LWIP, 5'd1, TIMEOUT, TIMEOUT, 32'h0BADCAFE, 4'b0000, 1'b1);

    // Reset in the second ACCESS cycle: everything drops asynchronously.
    @(posedge clk); #1;
    bus.opcode = LWIP; bus.subopcode = 5'd2; bus.issue = 1'b1;
    @(posedge clk); #1;
    bus.issue = 1'b0; bus.opcode = 6'h00;
    @(posedge clk); #2;
    check("pre_rst_ip_req", bus.ip_req, 1);
    rst = 1'b1;
    #1;
    check("arst_ip_req",   bus.ip_req,   0);
    check("arst_ip_sel",   bus.ip_sel,   0);
    check("arst_stall",    bus.stall,    0);
    check("arst_dataena",  bus.dataena,  0);
    check("arst_IP_write", bus.IP_write, 0);
    check("arst_err",      bus.err,      0);
    check("arst_rdata",    bus.rdata,    0);
    check("arst_err_code", bus.err_code, 0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b0;

    // Normal load after reset.
    exp_q.push_back(mk(2, 4'b0001, 0, 2, 1'b1, 1'b0, 2'b00, 32'hA5A50001));
    run_op(LWIP, 5'd0, 2, 2, 32'hA5A50001, 4'b0000, 1'b1);

    repeat (3) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ip_access_ctrl.md
Name: ip_access_ctrl

Overview:
Parametrised successor to the single-IP load/store decoder. It decodes LWIP/SWIP opcodes and uses subopcode to select one of NUM_IP attached IP blocks. It runs a request/ready handshake with the selected IP and stalls the CPU pipeline until completion or timeout. It also captures load data and flags an error on an illegal IP index or a timeout.

Parameters:
NUM_IP, 4, number of attached IP blocks (1..32)
SEL_W, 5, subopcode width; must satisfy 2**SEL_W >= NUM_IP
DATA_W, 32, IP data width
TIMEOUT, 16, max cycles in ACCESS before abort (>=2)
CNT_W, 5, timeout counter width; must satisfy 2**CNT_W > TIMEOUT

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
opcode  input  6  instruction opcode; LWIP=6'b111111, SWIP=6'b111110
subopcode  input  SEL_W  target IP index
issue  input  1  decode stage holds a valid instruction this cycle
ip_ready  input  NUM_IP  per-IP completion strobe
ip_rdata  input  NUM_IP*DATA_W  per-IP read data; IP i occupies bits [i*DATA_W +: DATA_W]
ip_sel  output  NUM_IP  one-hot select of the active IP
ip_req  output  1  access request to the selected IP
datarw  output  1  1 = write (SWIP) access in progress
dataena  output  1  1 = read (LWIP) access in progress
IP_write  output  1  one-cycle strobe: rdata valid, write it to the register file
rdata  output  DATA_W  captured load data
stall  output  1  freeze the CPU pipeline
err  output  1  one-cycle error strobe
err_code  output  2  01 = illegal index, 10 = timeout; held until the next err

Behaviour:
- Reset (async, rst=1): state=IDLE. ip_sel=0, ip_req=0, datarw=0, dataena=0, IP_write=0, rdata=0, stall=0, err=0, err_code=0, counter=0.
- States: IDLE, ACCESS, DONE, ERR. All outputs except stall are registered or decoded from the state and latched registers only.
- IDLE:
  - Access request (issue=1, opcode is LWIP or SWIP, subopcode<NUM_IP): latch sel=subopcode and rw=(opcode==SWIP). Go to ACCESS. stall=1 combinationally in this same cycle.
  - Illegal index (issue=1, opcode is LWIP or SWIP, subopcode>=NUM_IP): go to ERR with err_code<=01. stall=0 and no IP is touched.
  - Any other opcode, or issue=0: stay in IDLE, all outputs 0.
- ACCESS:
  - ip_req=1; ip_sel=one-hot(sel); datarw=rw; dataena=~rw; stall=1.
  - Counter increments every cycle, starting from 0 on entry.
  - If ip_ready[sel]=1: for a load, rdata<=ip_rdata[sel]; go to DONE. ip_ready bits of unselected IPs are ignored.
  - Else if counter==TIMEOUT-1: go to ERR with err_code<=10.
  - If ready and timeout coincide on the same cycle, ready wins.
- DONE (1 cycle):
  - ip_req=0; stall=0; IP_write=~rw. Go to IDLE.
  - Minimum latency from issue to DONE is 2 cycles (ready in the first ACCESS cycle).
- ERR (1 cycle):
  - err=1; stall=0; ip_req=0; IP_write=0; rdata unchanged. Go to IDLE.
- issue is ignored in ACCESS, DONE and ERR. The pipeline is stalled during ACCESS, and a new instruction is first sampled in the IDLE cycle after DONE/ERR.
- A store never modifies rdata. rdata holds its value until the next successful load.
- Reset asserted mid-access: immediate return to IDLE with reset values. No IP_write or err strobe is produced.

Test Plan:
- Reset, then issue LWIP with subopcode=2 and ip_ready[2] high 3 cycles later with ip_rdata[2]=32'hDEADBEEF -> ip_sel=4'b0100; ip_req and dataena high for 3 cycles; stall high from the issue cycle; one-cycle IP_write; rdata=32'hDEADBEEF.
- SWIP with subopcode=0 and ready on the first ACCESS cycle -> datarw=1 for 1 cycle; DONE next cycle; IP_write=0; rdata unchanged.
- LWIP with subopcode=5 (NUM_IP=4) -> no ip_req; err pulses the next cycle; err_code=01; stall stays 0.
- LWIP to IP 1 with ip_ready never asserted -> ip_req high for exactly TIMEOUT=16 cycles, then err=1 with err_code=10; IP_write=0.
- LWIP to IP 3 while ip_ready[0] and ip_ready[1] pulse -> the FSM stays in ACCESS and completes only on ip_ready[3].
- rst asserted in the 2nd ACCESS cycle -> all outputs 0 asynchronously; the next LWIP completes normally.
